// File: rtl/strobe_period_monitor.sv
// rtl/strobe_period_monitor.sv - measures the spacing of rate strobes against EXPECTED +/- TOLERANCE
// Reports each period, flags short/long/missing strobes and declares lock after LOCK_COUNT good periods.
module strobe_period_monitor #(
  parameter int EXPECTED   = 240,
  parameter int TOLERANCE  = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int CNT_W      = $clog2(2*EXPECTED+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_strobe,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err_short,
  output logic             o_err_long,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int STK_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT+1);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(EXPECTED - TOLERANCE);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(EXPECTED + TOLERANCE);
  localparam logic [CNT_W-1:0] P_LIMIT = CNT_W'(2*EXPECTED);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(LOCK_COUNT);
  localparam logic [STK_W-1:0] STK_PRE = STK_W'(LOCK_COUNT-1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] streak;
  logic [ERR_W-1:0] err_next;

  assign err_next = (o_err_count == '1) ? o_err_count : o_err_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      streak         <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_err_short    <= 1'b0;
      o_err_long     <= 1'b0;
      o_err_count    <= '0;
    end else begin
      o_period_valid <= 1'b0;
      o_err_short    <= 1'b0;
      o_err_long     <= 1'b0;
      if (!i_enable) begin
        state    <= IDLE;
        cnt      <= '0;
        streak   <= '0;
        o_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (i_strobe) begin
              state <= MEASURE;
              cnt   <= CNT_W'(1);
            end
          end
          MEASURE, LOCKED: begin
            if (i_strobe) begin
              // a strobe at cnt == P_LIMIT is a long period, not a timeout
              cnt            <= CNT_W'(1);
              o_period       <= cnt;
              o_period_valid <= 1'b1;
              if (cnt < P_MIN || cnt > P_MAX) begin
                o_err_short <= (cnt < P_MIN);
                o_err_long  <= (cnt > P_MAX);
                o_err_count <= err_next;
                streak      <= '0;
                state       <= MEASURE;
                o_locked    <= 1'b0;
              end else if (streak >= STK_PRE) begin
                streak   <= STK_MAX;
                state    <= LOCKED;
                o_locked <= 1'b1;
              end else begin
                streak <= streak + 1'b1;
              end
            end else if (cnt == P_LIMIT) begin
              // strobe lost: fall back to waiting for a fresh first strobe
              cnt         <= '0;
              streak      <= '0;
              state       <= ARM;
              o_locked    <= 1'b0;
              o_err_long  <= 1'b1;
              o_err_count <= err_next;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strobe_period_monitor.sv
// tb/tb_strobe_period_monitor.sv - scoreboard bench for strobe_period_monitor
// Stimulus pushes hand-computed responses tagged with their cycle; a negedge monitor pops and compares.
module tb_strobe_period_monitor;

  localparam int CNT_W = 9;
  localparam int ERR_W = 8;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_enable;
  logic             i_strobe;
  logic [CNT_W-1:0] o_period;
  logic             o_period_valid;
  logic             o_locked;
  logic             o_err_short;
  logic             o_err_long;
  logic [ERR_W-1:0] o_err_count;

  strobe_period_monitor #(
    .EXPECTED(240), .TOLERANCE(2), .LOCK_COUNT(4), .ERR_W(ERR_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_strobe(i_strobe),
    .o_period(o_period), .o_period_valid(o_period_valid), .o_locked(o_locked),
    .o_err_short(o_err_short), .o_err_long(o_err_long), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int cyc;
    int pv;
    int period;
    int sh;
    int lg;
    int lk;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_edge = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge i_clk) begin
    if (!i_reset && (o_period_valid || o_err_short || o_err_long)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_event", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("period_valid", int'(o_period_valid), e.pv);
        chk("period", int'(o_period), e.period);
        chk("err_short", int'(o_err_short), e.sh);
        chk("err_long", int'(o_err_long), e.lg);
        chk("locked", int'(o_locked), e.lk);
        chk("err_count", int'(o_err_count), e.err);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // strobe sampled 'gap' edges after the previous one; report=0 means no output event expected
  task automatic send(input int gap, input int report, input int period,
                      input int sh, input int lg, input int lk, input int err);
    exp_t e;
    repeat (gap - 1) tick();
    if (report != 0) begin
      e = '{cyc: cyc + 1, pv: 1, period: period, sh: sh, lg: lg, lk: lk, err: err};
      exp_q.push_back(e);
    end
    i_strobe  = 1'b1;
    last_edge = cyc + 1;
    tick();
    i_strobe  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, int'(o_period), 0);
    chk({tag, "_period_valid"}, int'(o_period_valid), 0);
    chk({tag, "_locked"}, int'(o_locked), 0);
    chk({tag, "_err_short"}, int'(o_err_short), 0);
    chk({tag, "_err_long"}, int'(o_err_long), 0);
    chk({tag, "_err_count"}, int'(o_err_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_strobe = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    i_reset  = 1'b0;
    i_enable = 1'b1;
    repeat (2) tick();

    // steady lock: 6 strobes, lock on the 5th
    send(3, 0, 0, 0, 0, 0, 0);
    send(240, 1, 240, 0, 0, 0, 0);
    send(240, 1, 240, 0, 0, 0, 0);
    send(240, 1, 240, 0, 0, 0, 0);
    send(240, 1, 240, 0, 0, 1, 0);
    send(240, 1, 240, 0, 0, 1, 0);

    // tolerance edges, then streak restarts from zero
    send(238, 1, 238, 0, 0, 1, 0);
    send(242, 1, 242, 0, 0, 1, 0);
    send(237, 1, 237, 1, 0, 0, 1);
    send(243, 1, 243, 0, 1, 0, 2);
    send(240, 1, 240, 0, 0, 0, 2);
    send(240, 1, 240, 0, 0, 0, 2);
    send(240, 1, 240, 0, 0, 0, 2);
    send(240, 1, 240, 0, 0, 1, 2);

    // loss of strobe while locked
    e = '{cyc: last_edge + 480, pv: 0, period: 240, sh: 0, lg: 1, lk: 0, err: 3};
    exp_q.push_back(e);
    repeat (490) tick();
    send(5, 0, 0, 0, 0, 0, 0);
    send(240, 1, 240, 0, 0, 0, 3);

    // strobe exactly at the timeout boundary is a measured long period
    send(480, 1, 480, 0, 1, 0, 4);
    send(240, 1, 240, 0, 0, 0, 4);
    send(240, 1, 240, 0, 0, 0, 4);
    send(240, 1, 240, 0, 0, 0, 4);
    send(240, 1, 240, 0, 0, 1, 4);

    // enable drop while locked
    i_enable = 1'b0;
    tick();
    chk("disable_locked", int'(o_locked), 0);
    chk("disable_err_count", int'(o_err_count), 4);
    chk("disable_period_hold", int'(o_period), 240);
    tick();

    // back-to-back strobes drive the error count into saturation
    i_enable = 1'b1;
    repeat (2) tick();
    send(3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 252; i++) begin
      send(1, 1, 1, 1, 0, 0, (i + 5 > 255) ? 255 : i + 5);
    end
    repeat (2) tick();

    i_reset = 1'b1;
    tick();
    check_all_zero("final_reset");
    i_reset = 1'b0;
    i_enable = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/strobe_period_monitor.md
# strobe_period_monitor

Receive-side checker for the single-cycle rate strobes produced by the clock-divider blocks. It measures the interval, in `i_clk` cycles, between successive `i_strobe` pulses. It compares each interval against `EXPECTED ± TOLERANCE` and declares lock after `LOCK_COUNT` consecutive good intervals. It flags short, long and missing strobes and keeps a saturating error count, so sample-rate logic can gate on `o_locked` and bring-up can confirm divider settings.

## Interface
Parameters:
- `EXPECTED`, 240: nominal strobe period in `i_clk` cycles; must be ≥ 2.
- `TOLERANCE`, 2: allowed ± deviation in cycles; must be < `EXPECTED`.
- `LOCK_COUNT`, 4: consecutive good periods needed to assert lock; must be ≥ 1.
- `ERR_W`, 8: width of the error counter.
- `CNT_W`, `$clog2(2*EXPECTED+1)`: width of the period counter and `o_period`.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  run/stop control. Low forces IDLE.
- `i_strobe`  in  1  single-cycle rate strobe under test.
- `o_period`  out  `CNT_W`  last measured period, registered.
- `o_period_valid`  out  1  one-cycle pulse when `o_period` updates.
- `o_locked`  out  1  level; asserted while lock holds.
- `o_err_short`  out  1  one-cycle pulse: period < `EXPECTED-TOLERANCE`.
- `o_err_long`  out  1  one-cycle pulse: period > `EXPECTED+TOLERANCE`, or timeout.
- `o_err_count`  out  `ERR_W`  saturating count of error pulses.

## Operation
- **States:**
  - IDLE: disabled.
  - ARM: waiting for the first strobe.
  - MEASURE: measuring, not locked.
  - LOCKED: measuring, lock asserted.
- **Reset:** state IDLE. Counter, good-streak and `o_err_count` all 0. `o_period` = 0. All pulse outputs and `o_locked` = 0.
- **`i_enable` low:** in any state, next cycle is IDLE. Counter and streak clear, `o_locked` = 0. `o_period` and `o_err_count` hold.
- IDLE → ARM when `i_enable` = 1.
- ARM → MEASURE on `i_strobe`. Counter loads 1. No period is reported for this first strobe.
- **Counter, in MEASURE/LOCKED:**
  - Increments each cycle without a strobe.
  - On a strobe, the measured period P = current counter value, then the counter reloads 1.
  - Strobes at cycles t and t+P therefore give period P.
- **Classification of P on each strobe in MEASURE/LOCKED:**
  - Good if `EXPECTED-TOLERANCE ≤ P ≤ EXPECTED+TOLERANCE`. Streak increments, saturating at `LOCK_COUNT`.
  - Short if P < `EXPECTED-TOLERANCE`. `o_err_short` pulses, streak clears, state goes to MEASURE.
  - Long if P > `EXPECTED+TOLERANCE`. `o_err_long` pulses, streak clears, state goes to MEASURE.
- **Lock:** MEASURE → LOCKED when the streak reaches `LOCK_COUNT` on a good period. `o_locked` rises in the same update. Any error leaves LOCKED.
- **Timeout:** counter equals `2*EXPECTED` with no strobe that cycle. Then `o_err_long` pulses, streak clears, `o_locked` clears, state goes to ARM. `o_period_valid` does not pulse and `o_period` holds.
- **Strobe at counter = `2*EXPECTED`:** the strobe wins. This is a measured long period, not a timeout.
- **Arithmetic:** comparisons are unsigned. `EXPECTED-TOLERANCE` and `EXPECTED+TOLERANCE` are elaboration-time constants. The counter never exceeds `2*EXPECTED`.
- **`o_err_count`:** increments by 1 on every `o_err_short` or `o_err_long` pulse and saturates at all-ones. Only `i_reset` clears it.

## Timing
- `i_strobe` sampled at cycle t (MEASURE/LOCKED) → at t+1:
  - `o_period` = P and `o_period_valid` = 1, for all classifications.
  - The error pulse is also at t+1.
  - `o_locked` and `o_err_count` update at t+1.
- Timeout detected at cycle t → `o_err_long` at t+1, `o_locked` low at t+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Back-to-back strobes (P = 1) are legal. They classify as short and `o_period_valid` pulses on consecutive cycles.
- `i_reset` overrides `i_enable` and mid-measurement state. The block returns to reset values at the next edge.

## Test plan
- **Steady lock:** defaults, enable, strobe every 240 cycles × 6 → five valid pulses with `o_period` = 240. `o_locked` rises one cycle after the 5th strobe. `o_err_count` = 0.
- **Tolerance edges:** periods 238, 242, 237, 243 → first two good; 237 gives `o_err_short`; 243 gives `o_err_long`. `o_err_count` = 2 and the streak restarts.
- **Loss of strobe while locked:** lock, then stop strobes → exactly 480 cycles after the last strobe, `o_err_long` pulses, `o_locked` falls, state ARM. The next strobe reports no period. The strobe after it reports a period again.
- **Boundary at timeout:** strobe exactly 480 cycles after the previous one → `o_period` = 480, `o_err_long` pulses, no timeout, state MEASURE.
- **Enable/reset mid-run:** drop `i_enable` while locked → `o_locked` = 0 next cycle and `o_err_count` holds. Force errors until the count reaches 255, add one more error → it stays 255. `i_reset` → every output returns to 0.
